// File: rtl/nco_ctrl_pkg.sv
// rtl/nco_ctrl_pkg.sv - shared state encoding and default widths for the NCO sweep controller
package nco_ctrl_pkg;

    localparam int ACC_W_DEFAULT   = 32;
    localparam int CNT_W_DEFAULT   = 16;
    localparam int DWELL_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// rtl/nco_sweep_ctrl_if.sv - sweep descriptor handshake between host and sweep controller
interface nco_sweep_ctrl_if #(
    parameter int ACCUMULATOR_WIDTH = nco_ctrl_pkg::ACC_W_DEFAULT,
    parameter int COUNT_WIDTH       = nco_ctrl_pkg::CNT_W_DEFAULT,
    parameter int DWELL_WIDTH       = nco_ctrl_pkg::DWELL_W_DEFAULT
);
    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [ACCUMULATOR_WIDTH-1:0] cfg_start;
    logic [ACCUMULATOR_WIDTH-1:0] cfg_step;
    logic [COUNT_WIDTH-1:0]       cfg_count;
    logic [DWELL_WIDTH-1:0]       cfg_dwell;

    modport master (
        output cfg_valid, cfg_start, cfg_step, cfg_count, cfg_dwell,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_step, cfg_count, cfg_dwell,
        output cfg_ready
    );
endinterface

// File: rtl/nco_dwell_timer.sv
// rtl/nco_dwell_timer.sv - loadable down-counter timing the dwell of each sweep point
module nco_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             tc
);
    logic [WIDTH-1:0] cnt;

    // Load wins over counting so a new point restarts its dwell on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - steps the NCO tuning word through a linear sweep with per-point dwell
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int ACCUMULATOR_WIDTH = ACC_W_DEFAULT,
    parameter int COUNT_WIDTH       = CNT_W_DEFAULT,
    parameter int DWELL_WIDTH       = DWELL_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nco_sweep_ctrl_if.slave              cfg,
    input  logic                         abort,
    output logic [ACCUMULATOR_WIDTH-1:0] phi_inc_o,
    output logic                         nco_clken_o,
    output logic                         step_stb,
    output logic                         busy,
    output logic                         done
);
    localparam int AW = ACCUMULATOR_WIDTH;
    localparam int CW = COUNT_WIDTH;
    localparam int DW = DWELL_WIDTH;

    state_t state, state_nxt;

    logic [AW-1:0] step_q;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] points_left;

    logic          dwell_tc;
    logic          accept, advance, finish;
    logic          tmr_load;
    logic [DW-1:0] tmr_value;

    logic [AW-1:0] phi_d;
    logic          clken_d;
    logic [CW-1:0] points_d;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (cfg.cfg_valid) state_nxt = RUN;
                RUN:  if (dwell_tc && (points_left <= CW'(1))) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath decode
    always_comb begin
        accept    = (state == IDLE) && cfg.cfg_valid && !abort;
        advance   = (state == RUN) && !abort && dwell_tc && (points_left > CW'(1));
        finish    = (state == RUN) && !abort && dwell_tc && (points_left <= CW'(1));

        phi_d     = phi_inc_o;
        clken_d   = nco_clken_o;
        points_d  = points_left;
        tmr_load  = 1'b0;
        tmr_value = dwell_q;

        if (abort) begin
            phi_d     = '0;
            clken_d   = 1'b0;
            points_d  = '0;
            tmr_load  = 1'b1;
            tmr_value = '0;
        end else if (accept) begin
            phi_d     = cfg.cfg_start;
            clken_d   = 1'b1;
            points_d  = (cfg.cfg_count == '0) ? CW'(1) : cfg.cfg_count;
            tmr_load  = 1'b1;
            tmr_value = cfg.cfg_dwell;
        end else if (advance) begin
            phi_d     = phi_inc_o + step_q;
            points_d  = points_left - CW'(1);
            tmr_load  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi_inc_o   <= '0;
            nco_clken_o <= 1'b0;
            step_stb    <= 1'b0;
            done        <= 1'b0;
            points_left <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
        end else begin
            phi_inc_o   <= phi_d;
            nco_clken_o <= clken_d;
            step_stb    <= accept || advance;
            done        <= finish;
            points_left <= points_d;
            if (accept) begin
                step_q  <= cfg.cfg_step;
                dwell_q <= cfg.cfg_dwell;
            end
        end
    end

    nco_dwell_timer #(
        .WIDTH (DW)
    ) u_dwell_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .en         (state == RUN),
        .tc         (dwell_tc)
    );

    assign busy          = (state == RUN);
    assign cfg.cfg_ready = (state == IDLE);
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - scoreboard bench for the NCO sweep controller
module tb_nco_sweep_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        abort;
    logic [31:0] phi_inc_o;
    logic        nco_clken_o, step_stb, busy, done;

    nco_sweep_ctrl_if #(.ACCUMULATOR_WIDTH(32), .COUNT_WIDTH(16), .DWELL_WIDTH(16)) cfg_bus ();

    nco_sweep_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg         (cfg_bus.slave),
        .abort       (abort),
        .phi_inc_o   (phi_inc_o),
        .nco_clken_o (nco_clken_o),
        .step_stb    (step_stb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] phi;
        logic        clken;
        logic        stb;
        logic        bsy;
        logic        dn;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] phi, input logic ck, stb, bsy, dn, rdy);
        exp_t e;
        e.phi = phi; e.clken = ck; e.stb = stb; e.bsy = bsy; e.dn = dn; e.rdy = rdy;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("phi_inc", phi_inc_o, e.phi);
        check("clken", {31'd0, nco_clken_o}, {31'd0, e.clken});
        check("step_stb", {31'd0, step_stb}, {31'd0, e.stb});
        check("busy", {31'd0, busy}, {31'd0, e.bsy});
        check("done", {31'd0, done}, {31'd0, e.dn});
        check("cfg_ready", {31'd0, cfg_bus.cfg_ready}, {31'd0, e.rdy});
    endtask

    // Expected outputs after each edge from the accept edge onward.
    task automatic push_sweep(input logic [31:0] start, step, input int n, d, idle_n);
        logic [31:0] phi;
        logic [31:0] last;
        int pts;
        pts  = (n < 1) ? 1 : n;
        phi  = start;
        last = start;
        for (int p = 0; p < pts; p++) begin
            for (int c = 0; c <= d; c++) push(phi, 1'b1, c == 0, 1'b1, 1'b0, 1'b0);
            last = phi;
            phi  = phi + step;
        end
        push(last, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < idle_n; i++) push(last, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic drive(input logic [31:0] start, step, input logic [15:0] count, dwell);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_start = start;
        cfg_bus.cfg_step  = step;
        cfg_bus.cfg_count = count;
        cfg_bus.cfg_dwell = dwell;
    endtask

    task automatic run_out();
        tick();
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_start = 32'hDEAD_BEEF;
        while (sb.size() != 0) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        abort   = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_start = '0;
        cfg_bus.cfg_step  = '0;
        cfg_bus.cfg_count = '0;
        cfg_bus.cfg_dwell = '0;
        repeat (2) @(posedge clk);
        #1;
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_check();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single tone, count=0 behaves as one point
        drive(32'h1000_0000, 32'h0000_0001, 16'd0, 16'd3);
        push_sweep(32'h1000_0000, 32'h0000_0001, 0, 3, 3);
        run_out();

        // Sweep up from a held tone
        drive(32'd100, 32'd10, 16'd4, 16'd2);
        push_sweep(32'd100, 32'd10, 4, 2, 2);
        run_out();

        // Down sweep wrapping through zero
        drive(32'h0000_0005, 32'hFFFF_FFFE, 16'd4, 16'd0);
        push_sweep(32'h0000_0005, 32'hFFFF_FFFE, 4, 0, 2);
        run_out();

        // Abort on the same edge as cfg_valid and an intermediate point expiry
        drive(32'd1000, 32'd1, 16'd3, 16'd1);
        push(32'd1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(32'd1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        cfg_bus.cfg_valid = 1'b0;
        tick();
        abort = 1'b1;
        drive(32'd5555, 32'd1, 16'd2, 16'd0);
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        abort = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();

        // Abort on last-point expiry suppresses done
        drive(32'd77, 32'd0, 16'd1, 16'd0);
        push(32'd77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        cfg_bus.cfg_valid = 1'b0;
        abort = 1'b1;
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        abort = 1'b0;
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Back-to-back: valid held through DONE, next accept in first IDLE cycle
        drive(32'd200, 32'd5, 16'd2, 16'd1);
        push_sweep(32'd200, 32'd5, 2, 1, 1);
        push_sweep(32'd9000, 32'd0, 1, 0, 2);
        tick();
        drive(32'd9000, 32'd0, 16'd1, 16'd0);
        repeat (6) tick();
        cfg_bus.cfg_valid = 1'b0;
        while (sb.size() != 0) tick();

        // Reset asserted mid-clock during a sweep
        drive(32'd7, 32'd1, 16'd5, 16'd3);
        push(32'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        cfg_bus.cfg_valid = 1'b0;
        tick();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_check();
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (sb.size() != 0) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
